// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - signal bundle between byte sources, the arbiter and the UART transmitter
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] data;
   logic [NUM_REQ-1:0]   last;
   logic [NUM_REQ-1:0]   ack;
   logic [NUM_REQ-1:0]   gnt;
   logic [7:0]           tx_data;
   logic                 tx_en;
   logic                 busy;

   modport master (
      output req, data, last, busy,
      input  ack, gnt, tx_data, tx_en
   );

   modport slave (
      input  req, data, last, busy,
      output ack, gnt, tx_data, tx_en
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-atomic arbiter in front of one shared UART transmitter
// Optional macro UART_TX_ARB_CRLF_EN appends CR/LF to every message that ends on last.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int BUSY_TIMEOUT = 16,
   parameter int MAX_MSG_LEN  = 32
) (
   input logic              clk,
   input logic              reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_MSG_LEN + 1);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_HI,
      WAIT_LO,
      NEXT
`ifdef UART_TX_ARB_CRLF_EN
      ,
      CR,
      LF
`endif
   } state_t;

   state_t               state;
   logic [IW-1:0]        ptr;
   logic [IW-1:0]        sel;
   logic [CW-1:0]        byte_cnt;
   logic [TW-1:0]        to_cnt;
   logic                 last_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic [7:0]           tx_data_q;
   logic                 tx_en_q;
`ifdef UART_TX_ARB_CRLF_EN
   logic [1:0]           crlf_ph;
`endif

   logic [IW-1:0]        pick;
   logic [IW-1:0]        cand;
   logic                 pick_vld;

   // Scan from farthest to nearest so the nearest requester after ptr wins.
   always_comb begin
      pick     = ptr;
      pick_vld = 1'b0;
      cand     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = IW'((int'(ptr) + i) % NUM_REQ);
         if (bus.req[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= IW'(NUM_REQ - 1);
         sel       <= '0;
         byte_cnt  <= '0;
         to_cnt    <= '0;
         last_q    <= 1'b0;
         gnt_q     <= '0;
         ack_q     <= '0;
         tx_data_q <= 8'h00;
         tx_en_q   <= 1'b0;
`ifdef UART_TX_ARB_CRLF_EN
         crlf_ph   <= 2'd0;
`endif
      end else begin
         ack_q   <= '0;
         tx_en_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt_q       <= '0;
                  gnt_q[pick] <= 1'b1;
                  ptr         <= pick;
                  sel         <= pick;
                  byte_cnt    <= '0;
`ifdef UART_TX_ARB_CRLF_EN
                  crlf_ph     <= 2'd0;
`endif
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (!bus.req[sel]) begin
                  gnt_q <= '0;
                  state <= IDLE;
               end else if (!bus.busy) begin
                  tx_data_q  <= bus.data[{sel, 3'b000} +: 8];
                  tx_en_q    <= 1'b1;
                  ack_q[sel] <= 1'b1;
                  last_q     <= bus.last[sel];
                  byte_cnt   <= byte_cnt + CW'(1);
                  to_cnt     <= '0;
                  state      <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               // A UART that never raises busy must not stall the line forever.
               if (bus.busy) begin
                  state <= WAIT_LO;
               end else if (to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                  state <= NEXT;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            WAIT_LO: begin
               if (!bus.busy) state <= NEXT;
            end
            NEXT: begin
`ifdef UART_TX_ARB_CRLF_EN
               if (crlf_ph == 2'd1) begin
                  state <= LF;
               end else if (crlf_ph == 2'd2) begin
                  gnt_q <= '0;
                  state <= IDLE;
               end else if (last_q) begin
                  state <= CR;
               end else if (byte_cnt == CW'(MAX_MSG_LEN)) begin
                  gnt_q <= '0;
                  state <= IDLE;
               end else begin
                  state <= LOAD;
               end
`else
               if (last_q || byte_cnt == CW'(MAX_MSG_LEN)) begin
                  gnt_q <= '0;
                  state <= IDLE;
               end else begin
                  state <= LOAD;
               end
`endif
            end
`ifdef UART_TX_ARB_CRLF_EN
            CR: begin
               if (!bus.busy) begin
                  tx_data_q <= 8'h0D;
                  tx_en_q   <= 1'b1;
                  crlf_ph   <= 2'd1;
                  to_cnt    <= '0;
                  state     <= WAIT_HI;
               end
            end
            LF: begin
               if (!bus.busy) begin
                  tx_data_q <= 8'h0A;
                  tx_en_q   <= 1'b1;
                  crlf_ph   <= 2'd2;
                  to_cnt    <= '0;
                  state     <= WAIT_HI;
               end
            end
`endif
            default: begin
               gnt_q <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.ack     = ack_q;
   assign bus.tx_data = tx_data_q;
   assign bus.tx_en   = tx_en_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with source and UART models
module tb_uart_tx_arbiter;
   localparam int NUM_REQ      = 3;
   localparam int BUSY_TIMEOUT = 16;
   localparam int MAX_MSG_LEN  = 32;
`ifdef UART_TX_ARB_CRLF_EN
   localparam int CRLF_N = 2;
`else
   localparam int CRLF_N = 0;
`endif

   typedef struct packed {
      logic [7:0] b;
      logic [2:0] src;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ),
      .BUSY_TIMEOUT(BUSY_TIMEOUT),
      .MAX_MSG_LEN(MAX_MSG_LEN)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   exp_t exp_q[$];
   int tx_cyc[$];
   logic [8:0] src_mem[NUM_REQ][64];
   int head[NUM_REQ];
   int tail[NUM_REQ];
   int cut[NUM_REQ];
   int ack_cnt[NUM_REQ];
   bit uart_auto = 1'b1;
   bit busy_force = 1'b0;
   bit pending = 1'b0;
   int busy_hold = 0;
   int gnt_falls = 0;
   int req_cyc = 0;
   logic [NUM_REQ-1:0] prev_gnt = '0;
   logic [NUM_REQ-1:0] prev_req = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: observe DUT outputs, step the UART model, then drive sources.
   task tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (busy_hold > 0) busy_hold--;
      if (pending) begin
         pending   = 1'b0;
         busy_hold = 10;
      end
      if (bus.tx_en) begin
         tx_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("tx_expected", 0, 1);
         end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(e.b));
            check("tx_gnt", 32'(bus.gnt), 32'(1) << e.src);
         end
         if (uart_auto) pending = 1'b1;
      end
      bus.busy = busy_force || (busy_hold > 0);
      if (bus.ack != '0) begin
         check("ack_with_tx", {30'b0, bus.tx_en, $onehot(bus.ack)}, 32'd3);
         check("ack_is_gnt", 32'(bus.ack), 32'(bus.gnt));
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.ack[i]) begin
               ack_cnt[i]++;
               if (head[i] < tail[i]) head[i]++;
               if (ack_cnt[i] == cut[i]) head[i] = tail[i];
            end
         end
      end
      if (prev_gnt != '0 && bus.gnt == '0) gnt_falls++;
      prev_gnt = bus.gnt;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (head[i] < tail[i]) begin
            bus.req[i]         = 1'b1;
            bus.data[8*i +: 8] = src_mem[i][head[i]][7:0];
            bus.last[i]        = src_mem[i][head[i]][8];
         end else begin
            bus.req[i]         = 1'b0;
            bus.data[8*i +: 8] = 8'h00;
            bus.last[i]        = 1'b0;
         end
      end
      if (bus.req != '0 && prev_req == '0) req_cyc = cyc;
      prev_req = bus.req;
   endtask

   task clear_tb();
      exp_q.delete();
      tx_cyc.delete();
      for (int i = 0; i < NUM_REQ; i++) begin
         head[i]    = 0;
         tail[i]    = 0;
         cut[i]     = -1;
         ack_cnt[i] = 0;
      end
      gnt_falls = 0;
   endtask

   task do_reset();
      clear_tb();
      reset = 1'b1;
      tick();
      tick();
      check("rst_gnt", 32'(bus.gnt), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_tx_en", 32'(bus.tx_en), 0);
      check("rst_tx_data", 32'(bus.tx_data), 0);
      reset = 1'b0;
      gnt_falls = 0;
   endtask

   task push(input int src, input logic [7:0] b, input bit lst, input bit expd);
      src_mem[src][tail[src]] = {lst, b};
      tail[src]++;
      if (expd) begin
         exp_q.push_back({b, 3'(src)});
`ifdef UART_TX_ARB_CRLF_EN
         if (lst) begin
            exp_q.push_back({8'h0D, 3'(src)});
            exp_q.push_back({8'h0A, 3'(src)});
         end
`endif
      end
   endtask

   function automatic bit sources_empty();
      for (int i = 0; i < NUM_REQ; i++)
         if (head[i] < tail[i]) return 1'b0;
      return 1'b1;
   endfunction

   task wait_done(input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         tick();
         done = sources_empty() && exp_q.size() == 0 && bus.gnt == '0;
      end
      check("done_in_budget", 32'(done), 1);
      repeat (12) tick();
   endtask

   function automatic int tx_at(input int n);
      if (n < tx_cyc.size()) return tx_cyc[n];
      return -1000;
   endfunction

   int rel;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      bus.req  = '0;
      bus.data = '0;
      bus.last = '0;
      bus.busy = 1'b0;
      clear_tb();

      // Single source, two-byte message
      do_reset();
      push(0, 8'h31, 1'b0, 1'b1);
      push(0, 8'h32, 1'b1, 1'b1);
      wait_done(500);
      check("t1_acks", ack_cnt[0], 2);
      check("t1_tx_count", tx_cyc.size(), 2 + CRLF_N);
      check("t1_gnt_falls", gnt_falls, 1);
      check("t1_latency", tx_at(0) - req_cyc, 2);

      // Round robin from reset, then re-request with pointer at 2
      do_reset();
      push(0, 8'h41, 1'b1, 1'b1);
      push(1, 8'h42, 1'b1, 1'b1);
      push(2, 8'h43, 1'b1, 1'b1);
      wait_done(800);
      check("t2_acks0", ack_cnt[0], 1);
      check("t2_acks1", ack_cnt[1], 1);
      check("t2_acks2", ack_cnt[2], 1);
      push(0, 8'h44, 1'b1, 1'b1);
      push(2, 8'h45, 1'b1, 1'b1);
      wait_done(800);
      check("t2_rr_acks0", ack_cnt[0], 2);
      check("t2_rr_acks2", ack_cnt[2], 2);

      // Abort: source 1 drops req after its first byte, source 2 pending
      do_reset();
      cut[1] = 1;
      push(1, 8'h51, 1'b0, 1'b1);
      push(1, 8'h52, 1'b1, 1'b0);
      push(2, 8'h61, 1'b1, 1'b1);
      wait_done(800);
      check("t3_acks1", ack_cnt[1], 1);
      check("t3_acks2", ack_cnt[2], 1);
      check("t3_gnt_falls", gnt_falls, 2);

      // Busy never rises: timeout spacing
      do_reset();
      uart_auto = 1'b0;
      push(0, 8'h71, 1'b0, 1'b1);
      push(0, 8'h72, 1'b0, 1'b1);
      push(0, 8'h73, 1'b1, 1'b1);
      wait_done(1000);
      uart_auto = 1'b1;
      check("t4_acks", ack_cnt[0], 3);
      check("t4_gap1", tx_at(1) - tx_at(0), BUSY_TIMEOUT + 2);
      check("t4_gap2", tx_at(2) - tx_at(1), BUSY_TIMEOUT + 2);

      // Busy already high at grant
      do_reset();
      busy_force = 1'b1;
      push(0, 8'h81, 1'b1, 1'b1);
      repeat (20) tick();
      check("t5_no_tx_while_busy", tx_cyc.size(), 0);
      check("t5_gnt_held", 32'(bus.gnt), 1);
      busy_force = 1'b0;
      tick();
      rel = cyc;
      wait_done(500);
      check("t5_tx_after_busy", tx_at(0) - rel, 1);
      check("t5_acks", ack_cnt[0], 1);

      // 40-byte message: forced release at 32, re-grant for the rest
      do_reset();
      for (int k = 0; k < 40; k++) push(0, 8'(8'h80 + k), k == 39, 1'b1);
      wait_done(3000);
      check("t5_long_acks", ack_cnt[0], 40);
      check("t5_long_gnt_falls", gnt_falls, 2);
      check("t5_long_tx_count", tx_cyc.size(), 40 + CRLF_N);

      // Reset while in WAIT_LO
      do_reset();
      push(0, 8'hA0, 1'b0, 1'b1);
      push(0, 8'hA1, 1'b0, 1'b0);
      push(0, 8'hA2, 1'b1, 1'b0);
      for (int k = 0; k < 100 && tx_cyc.size() == 0; k++) tick();
      check("t6_first_tx", tx_cyc.size(), 1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("t6_rst_gnt", 32'(bus.gnt), 0);
      check("t6_rst_tx_en", 32'(bus.tx_en), 0);
      check("t6_rst_tx_data", 32'(bus.tx_data), 0);
      clear_tb();
      tick();
      reset = 1'b0;
      push(0, 8'hB4, 1'b1, 1'b1);
      push(2, 8'hB5, 1'b1, 1'b1);
      wait_done(800);
      check("t6_acks0", ack_cnt[0], 1);
      check("t6_acks2", ack_cnt[2], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
